// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes, FSM states and
// the accept-time legality check.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } mau_state_e;

  // Size 2'b11 is reserved; halves need even addresses, words need 4-byte alignment.
  function automatic logic access_error(input logic [1:0] size, input logic [1:0] offset);
    return (size == 2'b11) ||
           ((size == SZ_HALF) && offset[0]) ||
           ((size == SZ_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane steering: extracts and extends load data from a memory word and
// merges right-aligned store data into the addressed lane of a word.
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        unsigned_i,
  input  logic [31:0] word_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    case (offset_i)
      2'd0:    lane_b = word_i[7:0];
      2'd1:    lane_b = word_i[15:8];
      2'd2:    lane_b = word_i[23:16];
      default: lane_b = word_i[31:24];
    endcase
    lane_h = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    load_data_o = word_i;
    merged_o    = word_i;
    case (size_i)
      SZ_BYTE: begin
        load_data_o = {{24{~unsigned_i & lane_b[7]}}, lane_b};
        case (offset_i)
          2'd0:    merged_o[7:0]   = store_data_i[7:0];
          2'd1:    merged_o[15:8]  = store_data_i[7:0];
          2'd2:    merged_o[23:16] = store_data_i[7:0];
          default: merged_o[31:24] = store_data_i[7:0];
        endcase
      end
      SZ_HALF: begin
        load_data_o = {{16{~unsigned_i & lane_h[15]}}, lane_h};
        if (offset_i[1]) merged_o[31:16] = store_data_i[15:0];
        else             merged_o[15:0]  = store_data_i[15:0];
      end
      default: begin
        load_data_o = word_i;
        merged_o    = store_data_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one request at a time, read-modify-write for
// sub-word stores, one-cycle response pulse with sticky data/error.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic [1:0]  dbg_state_o
);

  mau_state_e  state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] store_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic [31:0] load_data;
  logic [31:0] merged_word;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so at most one access is in flight and the
  // requester may change its fields freely after the transfer cycle.
  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP);
  assign mem_read       = (state_q == READ);
  assign mem_write      = (state_q == WRITE);
  assign mem_address    = {addr_q[31:2], 2'b00};
  assign mem_write_data = mem_wdata_q;
  assign resp_rdata     = rdata_q;
  assign resp_error     = error_q;
  assign dbg_state_o    = state_q;

  lsu_lane_align u_lane (
    .size_i       (size_q),
    .offset_i     (addr_q[1:0]),
    .unsigned_i   (unsigned_q),
    .word_i       (mem_read_data),
    .store_data_i (store_q),
    .load_data_o  (load_data),
    .merged_o     (merged_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= SZ_BYTE;
      unsigned_q  <= 1'b0;
      addr_q      <= 32'h0;
      store_q     <= 32'h0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            store_q    <= req_wdata;
            if (access_error(req_size, req_addr[1:0])) begin
              rdata_q <= 32'h0;
              error_q <= 1'b1;
              state_q <= RESP;
            end else if (req_write && (req_size == SZ_WORD)) begin
              mem_wdata_q <= req_wdata;
              state_q     <= WRITE;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          // The read word is consumed here, so nothing needs to survive past this edge.
          if (write_q) begin
            mem_wdata_q <= merged_word;
            state_q     <= WRITE;
          end else begin
            rdata_q <= load_data;
            error_q <= 1'b0;
            state_q <= RESP;
          end
        end
        WRITE: begin
          rdata_q <= 32'h0;
          error_q <= 1'b0;
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
